// File: rtl/lift_scheduler_if.sv
// Car bus between the call panel / display / motor logic and the lift scheduler.
// The master drives calls and the slow tick; the slave reports car status.
interface lift_scheduler_if #(
    parameter int unsigned N_FLOORS = 8
);
    localparam int unsigned FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;

    logic                tick;
    logic [N_FLOORS-1:0] call_req;
    logic [N_FLOORS-1:0] pending;
    logic [FW-1:0]       cur_floor;
    logic                dir_up;
    logic                moving;
    logic                door_open;
    logic [1:0]          state;

    modport master (
        output tick, call_req,
        input  pending, cur_floor, dir_up, moving, door_open, state
    );

    modport slave (
        input  tick, call_req,
        output pending, cur_floor, dir_up, moving, door_open, state
    );
endinterface

// File: rtl/lift_scheduler.sv
// SCAN floor sequencer: latches calls, keeps travelling while calls lie ahead, then reverses.
// Travel and door dwell are timed in divider ticks.
module lift_scheduler #(
    parameter int unsigned N_FLOORS   = 8,
    parameter int unsigned MOVE_TICKS = 3,
    parameter int unsigned DOOR_TICKS = 5
) (
    input  logic            clk_100MHz,
    input  logic            rst,
    lift_scheduler_if.slave bus
);
    localparam int unsigned FW        = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int unsigned MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int unsigned CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CW-1:0] MoveLast = CW'(MOVE_TICKS - 1);
    localparam logic [CW-1:0] DoorLast = CW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StMoveUp   = 2'd1,
        StMoveDown = 2'd2,
        StDoor     = 2'd3
    } state_e;

    state_e              r_state;
    logic [FW-1:0]       r_cur_floor;
    logic                r_dir_up;
    logic [N_FLOORS-1:0] r_pending;
    logic [CW-1:0]       r_cnt;

    state_e              w_state_nxt;
    logic [FW-1:0]       w_floor_nxt;
    logic                w_dir_nxt;
    logic [N_FLOORS-1:0] w_pending_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [N_FLOORS-1:0] w_req;
    logic [N_FLOORS-1:0] w_clr;
    logic [FW-1:0]       w_step_floor;
    logic                w_above;
    logic                w_below;
    logic                w_ahead;

    // Floors strictly above (up=1) or strictly below (up=0) floor f.
    function automatic logic [N_FLOORS-1:0] beyond_mask(input logic [FW-1:0] f, input logic up);
        logic [N_FLOORS-1:0] m;
        for (int i = 0; i < N_FLOORS; i++) begin
            m[i] = up ? (i > int'(f)) : (i < int'(f));
        end
        return m;
    endfunction

    always_comb begin
        w_req        = r_pending | bus.call_req;
        w_step_floor = (r_state == StMoveDown) ? r_cur_floor - FW'(1) : r_cur_floor + FW'(1);
        w_above      = |(w_req & beyond_mask(r_cur_floor, 1'b1));
        w_below      = |(w_req & beyond_mask(r_cur_floor, 1'b0));
        w_ahead      = |(w_req & beyond_mask(w_step_floor, r_state == StMoveUp));
        w_state_nxt  = r_state;
        w_floor_nxt  = r_cur_floor;
        w_dir_nxt    = r_dir_up;
        w_cnt_nxt    = r_cnt;
        w_clr        = '0;

        case (r_state)
            StIdle: begin
                if (w_req[r_cur_floor]) begin
                    w_state_nxt = StDoor;
                    w_clr       = N_FLOORS'(1) << r_cur_floor;
                    w_cnt_nxt   = '0;
                end else if (r_dir_up ? w_above : !w_below && w_above) begin
                    w_state_nxt = StMoveUp;
                    w_dir_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (w_below) begin
                    w_state_nxt = StMoveDown;
                    w_dir_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            StMoveUp, StMoveDown: begin
                if (bus.tick) begin
                    if (r_cnt == MoveLast) begin
                        // Arrival: the new floor decides stop / continue / idle this cycle.
                        w_floor_nxt = w_step_floor;
                        w_cnt_nxt   = '0;
                        if (w_req[w_step_floor]) begin
                            w_state_nxt = StDoor;
                            w_clr       = N_FLOORS'(1) << w_step_floor;
                        end else if (!w_ahead) begin
                            w_state_nxt = StIdle;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            StDoor: begin
                w_clr = N_FLOORS'(1) << r_cur_floor;
                if (bus.call_req[r_cur_floor]) begin
                    w_cnt_nxt = '0;
                end else if (bus.tick) begin
                    if (r_cnt == DoorLast) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        w_pending_nxt = w_req & ~w_clr;
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cur_floor <= '0;
            r_dir_up    <= 1'b1;
            r_pending   <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_floor <= w_floor_nxt;
            r_dir_up    <= w_dir_nxt;
            r_pending   <= w_pending_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign bus.pending   = r_pending;
    assign bus.cur_floor = r_cur_floor;
    assign bus.dir_up    = r_dir_up;
    assign bus.state     = r_state;
    assign bus.moving    = (r_state == StMoveUp) || (r_state == StMoveDown);
    assign bus.door_open = (r_state == StDoor);
endmodule

// File: tb/tb_lift_scheduler.sv
// Bench for lift_scheduler: a countdown-based SCAN model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_lift_scheduler;
    localparam int unsigned N  = 8;
    localparam int          MT = 2;
    localparam int          DT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_down   = 0;
    int   d0;

    lift_scheduler_if #(.N_FLOORS(N)) bus ();

    lift_scheduler #(
        .N_FLOORS  (N),
        .MOVE_TICKS(MT),
        .DOOR_TICKS(DT)
    ) dut (
        .clk_100MHz(clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 up, 2 down, 3 door; m_left counts ticks remaining.
    int         m_floor = 0;
    bit         m_up    = 1'b1;
    bit [N-1:0] m_pend  = '0;
    int         m_mode  = 0;
    int         m_left  = 0;

    function automatic bit any_past(bit [N-1:0] r, int f, bit up);
        for (int i = 0; i < N; i++) begin
            if (r[i] && (up ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_floor <= 0;
            m_up    <= 1'b1;
            m_pend  <= '0;
            m_mode  <= 0;
            m_left  <= 0;
        end else begin
            automatic int         f    = m_floor;
            automatic bit         up   = m_up;
            automatic int         mode = m_mode;
            automatic int         left = m_left;
            automatic bit [N-1:0] req  = m_pend | bus.call_req;
            automatic bit [N-1:0] pend = req;
            case (mode)
                0: begin
                    if (req[f]) begin
                        mode = 3; left = DT; pend[f] = 1'b0;
                    end else begin
                        if (!any_past(req, f, up) && any_past(req, f, !up)) up = !up;
                        if (any_past(req, f, up)) begin
                            mode = up ? 1 : 2; left = MT;
                        end
                    end
                end
                1, 2: begin
                    if (bus.tick) begin
                        left = left - 1;
                        if (left == 0) begin
                            f = f + ((mode == 1) ? 1 : -1);
                            if (req[f]) begin
                                mode = 3; left = DT; pend[f] = 1'b0;
                            end else if (any_past(req, f, mode == 1)) begin
                                left = MT;
                            end else begin
                                mode = 0;
                            end
                        end
                    end
                end
                default: begin
                    pend[f] = 1'b0;
                    if (bus.call_req[f]) left = DT;
                    else if (bus.tick) begin
                        left = left - 1;
                        if (left == 0) mode = 0;
                    end
                end
            endcase
            m_floor <= f;
            m_up    <= up;
            m_pend  <= pend;
            m_mode  <= mode;
            m_left  <= left;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    endtask

    always @(negedge clk) begin
        if (bus.state == 2'd2) n_down++;
        chk("model pending",   32'(bus.pending),   32'(m_pend));
        chk("model cur_floor", 32'(bus.cur_floor), m_floor);
        chk("model dir_up",    32'(bus.dir_up),    32'(m_up));
        chk("model state",     32'(bus.state),     m_mode);
        chk("model moving",    32'(bus.moving),    32'(m_mode == 1 || m_mode == 2));
        chk("model door_open", 32'(bus.door_open), 32'(m_mode == 3));
    end

    // Applies inputs for exactly one rising edge, returns just after it.
    task automatic step(input bit t, input bit [N-1:0] req);
        @(negedge clk);
        bus.tick     = t;
        bus.call_req = req;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0);
            step(1'b0, '0);
            step(1'b0, '0);
            step(1'b1, '0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.tick     = 1'b0;
        bus.call_req = '0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.tick     = 1'b0;
        bus.call_req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset state", 32'(bus.state), 0);
        chk("reset floor", 32'(bus.cur_floor), 0);
        chk("reset dir_up", 32'(bus.dir_up), 1);
        chk("reset pending", 32'(bus.pending), 0);

        // Single call to floor 3.
        step(1'b0, 8'h08);
        chk("t2 move_up next clk", 32'(bus.state), 1);
        chk("t2 pending latched", 32'(bus.pending), 32'h08);
        ticks(5);
        chk("t2 floor after 5 ticks", 32'(bus.cur_floor), 2);
        ticks(1);
        chk("t2 arrive floor", 32'(bus.cur_floor), 3);
        chk("t2 door_open on arrival", 32'(bus.door_open), 1);
        chk("t2 pending cleared", 32'(bus.pending), 0);
        ticks(2);
        chk("t2 door still open", 32'(bus.state), 3);
        ticks(1);
        chk("t2 idle after door", 32'(bus.state), 0);

        // At floor 3, calls to 5 and 1: serve 5 then reverse to 1.
        step(1'b0, 8'h22);
        chk("t3 move_up first", 32'(bus.state), 1);
        ticks(4);
        chk("t3 floor 5", 32'(bus.cur_floor), 5);
        chk("t3 door at 5", 32'(bus.state), 3);
        chk("t3 pending 1 left", 32'(bus.pending), 32'h02);
        ticks(3);
        chk("t3 idle at 5", 32'(bus.state), 0);
        step(1'b0, '0);
        chk("t3 reverse down", 32'(bus.state), 2);
        chk("t3 dir_up cleared", 32'(bus.dir_up), 0);
        ticks(8);
        chk("t3 floor 1", 32'(bus.cur_floor), 1);
        chk("t3 door at 1", 32'(bus.state), 3);
        chk("t3 pending empty", 32'(bus.pending), 0);
        ticks(3);
        chk("t3 idle at 1", 32'(bus.state), 0);

        // Heading to 6, call to 4 raised at floor 2.
        do_reset();
        step(1'b0, 8'h40);
        ticks(4);
        chk("t4 at floor 2", 32'(bus.cur_floor), 2);
        step(1'b0, 8'h10);
        chk("t4 pending 4 and 6", 32'(bus.pending), 32'h50);
        ticks(4);
        chk("t4 stop at 4", 32'(bus.cur_floor), 4);
        chk("t4 door at 4", 32'(bus.state), 3);
        ticks(3);
        step(1'b0, '0);
        chk("t4 resume up", 32'(bus.state), 1);
        ticks(4);
        chk("t4 reach 6", 32'(bus.cur_floor), 6);
        chk("t4 door at 6", 32'(bus.door_open), 1);
        ticks(3);

        // Door reload at floor 2.
        step(1'b0, 8'h04);
        chk("t5 move down", 32'(bus.state), 2);
        ticks(8);
        chk("t5 floor 2 door", 32'(bus.cur_floor), 2);
        ticks(2);
        step(1'b0, 8'h04);
        chk("t5 call at floor not latched", 32'(bus.pending), 0);
        ticks(2);
        chk("t5 door held after reload", 32'(bus.state), 3);
        ticks(1);
        chk("t5 idle after full dwell", 32'(bus.state), 0);

        // Call at floor 0 while at floor 0.
        do_reset();
        d0 = n_down;
        step(1'b0, 8'h01);
        chk("t6 door next clk", 32'(bus.state), 3);
        chk("t6 no motion", 32'(bus.moving), 0);
        ticks(3);
        chk("t6 idle", 32'(bus.state), 0);
        chk("t6 floor 0", 32'(bus.cur_floor), 0);
        chk("t6 never moved down", n_down - d0, 0);

        // Random activity, then asynchronous reset mid-cycle.
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 2) == 0,
                 ($urandom_range(0, 5) == 0) ? N'($urandom) : N'(0));
        end
        step(1'b0, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst state", 32'(bus.state), 0);
        chk("async rst floor", 32'(bus.cur_floor), 0);
        chk("async rst pending", 32'(bus.pending), 0);
        chk("async rst dir_up", 32'(bus.dir_up), 1);
        chk("async rst door", 32'(bus.door_open), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0);
        step(1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lift_scheduler.md
Name: lift_scheduler

Overview:
- Floor-sequencing controller for the lift car.
- Collects call requests into a pending-floor register and chooses the travel direction with a SCAN policy: keep going while calls remain ahead, then reverse.
- Times floor-to-floor travel and door dwell in units of a slow tick from the clock divider.
- Drives the car position, direction, motion and door status to the display and motor logic.

Parameters:
N_FLOORS, 8, number of floors (2..16); floor index width FW = $clog2(N_FLOORS) (localparam, min 1)
MOVE_TICKS, 3, ticks needed to travel one floor (>=1)
DOOR_TICKS, 5, ticks the door stays open (>=1)

Ports:
clk_100MHz  in   1         system clock, all state on posedge
rst         in   1         asynchronous, active-high reset
tick        in   1         1-cycle enable pulse from divider, synchronous to clk_100MHz
call_req    in   N_FLOORS  call request per floor, level or pulse, sampled every clk cycle
pending     out  N_FLOORS  registered outstanding calls
cur_floor   out  FW        current floor index
dir_up      out  1         1 = up preference/direction, 0 = down
moving      out  1         1 in MOVE_UP/MOVE_DOWN
door_open   out  1         1 in DOOR
state       out  2         IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR=3

Behaviour:
- Reset (async, immediate): state=IDLE, cur_floor=0, dir_up=1, pending=0, tick counter=0, moving=0, door_open=0. Reset mid-move or mid-door abandons all calls.
- Outputs are registered. moving and door_open decode from state.
- pending: each cycle pending <= (pending | call_req) & ~clr.
  - clr is one-hot at cur_floor while state==DOOR, or on the cycle of entering DOOR.
  - A call to cur_floor during DOOR is never latched. It reloads the door counter to 0 (door stays open a full DOOR_TICKS).
- above = any pending bit > cur_floor; below = any bit < cur_floor. Computed from the registered pending, ORed with the same-cycle call_req.
- IDLE, evaluated every clk cycle (no tick needed), first match wins:
  - pending/call at cur_floor: go to DOOR.
  - dir_up=1: above -> MOVE_UP; else below -> MOVE_DOWN with dir_up<=0.
  - dir_up=0: below -> MOVE_DOWN; else above -> MOVE_UP with dir_up<=1.
  - Otherwise stay in IDLE.
  - Counter is cleared on leaving IDLE.
- MOVE_UP / MOVE_DOWN:
  - Counter increments on tick only.
  - On the tick where counter==MOVE_TICKS-1: cur_floor += 1 or -= 1, counter<=0.
  - Then, in the same cycle, using the new floor: call at new floor -> DOOR; else a call further in the direction -> stay; else IDLE.
  - Calls arriving mid-floor that are ahead are served on arrival. Calls behind wait for the reversal.
- DOOR:
  - Counter increments on tick.
  - On the tick where counter==DOOR_TICKS-1: state<=IDLE, counter<=0. The next direction is decided in IDLE on the following cycle.
- Floor bounds: the car only moves when a call lies beyond it, so cur_floor never leaves 0..N_FLOORS-1. No wrap-around.
- Ticks seen while in IDLE are ignored.
- Latency:
  - Call to MOVE state: 1 clk from IDLE.
  - Travel of k floors: k*MOVE_TICKS ticks.
  - Arrival to door_open: same cycle as the cur_floor update.

Test Plan:
- Assert rst during random activity -> outputs go to reset values without a clock edge; pending=0, cur_floor=0, state=IDLE.
- N=8, MOVE_TICKS=2, DOOR_TICKS=3, tick every 4 clks, single pulse call_req[3] -> MOVE_UP next clk; cur_floor=3 after 6 ticks with door_open=1 and pending[3]=0 in the same cycle; IDLE after 3 more ticks.
- Idle at floor 3 with dir_up=1, simultaneous calls to floors 5 and 1 -> serves 5 first (door opens), then reverses, dir_up=0, serves 1; pending=0 at end.
- Moving up from 0 toward 6, call_req[4] raised while cur_floor=2 -> car stops at 4 (DOOR), then continues to 6.
- In DOOR at floor 2 after 2 ticks, call_req[2] pulse -> counter reloads; door stays open 3 further ticks (5 total); pending[2] stays 0.
- Car at floor 0, only call is floor 0 -> DOOR next clk, no motion; cur_floor stays 0 and MOVE_DOWN is never entered.
